// File: rtl/laser_safety_sequencer_pkg.sv
// laser_seq_pkg: state encodings, fault codes and default timing for the laser safety sequencer
package laser_seq_pkg;

   typedef enum logic [2:0] {
      S_OFF      = 3'd0,
      S_SETTLE   = 3'd1,
      S_ARMED    = 3'd2,
      S_FAULT    = 3'd3,
      S_COOLDOWN = 3'd4
   } seq_state_t;

   localparam logic [2:0] F_NONE        = 3'd0;
   localparam logic [2:0] F_CURRENT     = 3'd1;
   localparam logic [2:0] F_PULSE_UPPER = 3'd2;
   localparam logic [2:0] F_PULSE_LOWER = 3'd3;
   localparam logic [2:0] F_RATE_LOWER  = 3'd4;
   localparam logic [2:0] F_PWR_GOOD    = 3'd5;
   localparam logic [2:0] F_WDT         = 3'd6;

   localparam int DEF_CNT_W             = 32;
   localparam int DEF_PWR_SETTLE_CYCLES = 25000;
   localparam int DEF_WDT_CYCLES        = 25000000;
   localparam int DEF_COOLDOWN_CYCLES   = 2500000;

   // lowest code wins when several limit flags rise together
   function automatic logic [2:0] limit_code(input logic cur, input logic pu, input logic pl, input logic rl);
      return cur ? F_CURRENT : pu ? F_PULSE_UPPER : pl ? F_PULSE_LOWER : rl ? F_RATE_LOWER : F_NONE;
   endfunction

endpackage

// File: rtl/laser_safety_sequencer_if.sv
// laser_seq_if: host/limit_check controls in, driver and status outputs back
interface laser_seq_if;
   logic       enable_req;
   logic       wdt_en;
   logic       wdt_kick;
   logic       clear_fail;
   logic       pwr_good;
   logic       laser_ready;
   logic       pulse_lower_fail;
   logic       pulse_upper_fail;
   logic       rate_lower_fail;
   logic       current_fail;
   logic       laser_pwr_en;
   logic       ta_shutdown;
   logic       clear_limits;
   logic       watchdog_timeout;
   logic [2:0] fault_code;
   logic [2:0] seq_state;

   modport master (
      output enable_req, wdt_en, wdt_kick, clear_fail, pwr_good, laser_ready,
             pulse_lower_fail, pulse_upper_fail, rate_lower_fail, current_fail,
      input  laser_pwr_en, ta_shutdown, clear_limits, watchdog_timeout, fault_code, seq_state
   );

   modport slave (
      input  enable_req, wdt_en, wdt_kick, clear_fail, pwr_good, laser_ready,
             pulse_lower_fail, pulse_upper_fail, rate_lower_fail, current_fail,
      output laser_pwr_en, ta_shutdown, clear_limits, watchdog_timeout, fault_code, seq_state
   );
endinterface

// File: rtl/laser_safety_sequencer_timer.sv
// seq_timer: saturating up-counter with clear, enable and terminal-count compare
module seq_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] tc,
   output logic             done
);
   logic [CNT_W-1:0] cnt;

   // count up, hold at all-ones instead of wrapping
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en && cnt != '1) cnt <= cnt + 1'b1;

   assign done = cnt == tc;
endmodule

// File: rtl/laser_safety_sequencer.sv
// laser_safety_sequencer: arms the laser driver and TA only while supply, limits and host watchdog are healthy
module laser_safety_sequencer
   import laser_seq_pkg::*;
#(
   parameter int CNT_W             = DEF_CNT_W,
   parameter int PWR_SETTLE_CYCLES = DEF_PWR_SETTLE_CYCLES,
   parameter int WDT_CYCLES        = DEF_WDT_CYCLES,
   parameter int COOLDOWN_CYCLES   = DEF_COOLDOWN_CYCLES
) (
   input logic        clk,
   input logic        rst,
   laser_seq_if.slave io
);
   seq_state_t state, nxt;
   logic       pg_m, pg_s, en_d;
   logic       fault_any, st_done, wdt_done, wdt_exp;
   logic [2:0] lim_code, code, code_nxt;
   logic       to, to_nxt, cl_nxt;
   logic       pwr_en, ta, cl;
   logic [CNT_W-1:0] st_tc;

   assign fault_any = io.current_fail | io.pulse_upper_fail | io.pulse_lower_fail | io.rate_lower_fail;
   assign lim_code  = limit_code(io.current_fail, io.pulse_upper_fail, io.pulse_lower_fail, io.rate_lower_fail);
   assign st_tc     = state == S_SETTLE ? CNT_W'(PWR_SETTLE_CYCLES - 1) : CNT_W'(COOLDOWN_CYCLES - 1);
   assign wdt_exp   = state == S_ARMED && io.wdt_en && wdt_done && !io.wdt_kick;

   // en_d resets high so a request already held through reset needs a fresh low->high edge
   always_ff @(posedge clk)
      if (rst) begin
         pg_m <= 1'b0;
         pg_s <= 1'b0;
         en_d <= 1'b1;
      end else begin
         pg_m <= io.pwr_good;
         pg_s <= pg_m;
         en_d <= io.enable_req;
      end

   seq_timer #(.CNT_W(CNT_W)) u_state_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (nxt != state),
      .en   (1'b1),
      .tc   (st_tc),
      .done (st_done)
   );

   seq_timer #(.CNT_W(CNT_W)) u_wdt_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (io.wdt_kick || !io.wdt_en || state != S_ARMED),
      .en   (1'b1),
      .tc   (CNT_W'(WDT_CYCLES - 1)),
      .done (wdt_done)
   );

   // next state with fault > disarm > progress priority; fault code latched on FAULT entry only
   always_comb begin
      nxt      = state;
      code_nxt = code;
      to_nxt   = to;
      cl_nxt   = 1'b0;
      case (state)
         S_OFF:
            if (io.enable_req && !en_d && io.laser_ready && pg_s && !fault_any) begin
               nxt      = S_SETTLE;
               code_nxt = F_NONE;
               to_nxt   = 1'b0;
            end
         S_SETTLE:
            if (fault_any) begin
               nxt      = S_FAULT;
               code_nxt = lim_code;
            end else if (!pg_s) begin
               nxt      = S_FAULT;
               code_nxt = F_PWR_GOOD;
            end else if (!io.enable_req) nxt = S_OFF;
            else if (st_done) nxt = S_ARMED;
         S_ARMED:
            if (fault_any) begin
               nxt      = S_FAULT;
               code_nxt = lim_code;
            end else if (!pg_s) begin
               nxt      = S_FAULT;
               code_nxt = F_PWR_GOOD;
            end else if (wdt_exp) begin
               nxt      = S_FAULT;
               code_nxt = F_WDT;
               to_nxt   = 1'b1;
            end else if (!io.enable_req) nxt = S_OFF;
         S_FAULT:
            if (io.clear_fail && !fault_any) begin
               nxt    = S_COOLDOWN;
               cl_nxt = 1'b1;
            end
         S_COOLDOWN:
            if (fault_any) begin
               nxt      = S_FAULT;
               code_nxt = lim_code;
            end else if (st_done) nxt = S_OFF;
         default: nxt = S_OFF;
      endcase
   end

   // outputs decoded from the next state so they appear together with the state change
   always_ff @(posedge clk)
      if (rst) begin
         state  <= S_OFF;
         pwr_en <= 1'b0;
         ta     <= 1'b1;
         cl     <= 1'b0;
         to     <= 1'b0;
         code   <= F_NONE;
      end else begin
         state  <= nxt;
         pwr_en <= nxt == S_SETTLE || nxt == S_ARMED;
         ta     <= nxt != S_ARMED;
         cl     <= cl_nxt;
         to     <= to_nxt;
         code   <= code_nxt;
      end

   assign io.laser_pwr_en     = pwr_en;
   assign io.ta_shutdown      = ta;
   assign io.clear_limits     = cl;
   assign io.watchdog_timeout = to;
   assign io.fault_code       = code;
   assign io.seq_state        = state;
endmodule

// File: tb/tb_laser_safety_sequencer.sv
// tb_laser_safety_sequencer: directed scoreboard bench for the laser safety sequencer
module tb_laser_safety_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [9:0] exp_q[$];
   string      tag_q[$];

   laser_seq_if io();

   laser_safety_sequencer #(
      .CNT_W             (32),
      .PWR_SETTLE_CYCLES (8),
      .WDT_CYCLES        (16),
      .COOLDOWN_CYCLES   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   always #20 clk = ~clk;

   // expected vector layout: {en, ta, clear_limits, watchdog_timeout, fault_code, seq_state}
   function automatic logic [9:0] v(input logic en, input logic ta, input logic cl, input logic to,
                                    input logic [2:0] code, input logic [2:0] st);
      return {en, ta, cl, to, code, st};
   endfunction

   task automatic pop_check();
      logic [9:0] e, o;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = {io.laser_pwr_en, io.ta_shutdown, io.clear_limits, io.watchdog_timeout, io.fault_code, io.seq_state};
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", t, o, e);
      end
   endtask

   task automatic step(input string tag, input logic [9:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic settle_to_armed(input string tag);
      repeat (7) step({tag, "_settle"}, v(1, 1, 0, 0, 0, 1));
      step({tag, "_armed"}, v(1, 0, 0, 0, 0, 2));
   endtask

   initial begin
      io.enable_req = 0; io.wdt_en = 0; io.wdt_kick = 0; io.clear_fail = 0;
      io.pwr_good = 1; io.laser_ready = 1;
      io.pulse_lower_fail = 0; io.pulse_upper_fail = 0; io.rate_lower_fail = 0; io.current_fail = 0;
      step("reset0", v(0, 1, 0, 0, 0, 0));
      step("reset1", v(0, 1, 0, 0, 0, 0));
      rst = 0;
      repeat (3) step("off_idle", v(0, 1, 0, 0, 0, 0));

      io.enable_req = 1;
      step("t1_enter_settle", v(1, 1, 0, 0, 0, 1));
      settle_to_armed("t1");

      io.current_fail = 1; io.rate_lower_fail = 1;
      step("t2_fault_code1", v(0, 1, 0, 0, 1, 3));
      io.current_fail = 0;

      io.clear_fail = 1;
      step("t3_clear_blocked", v(0, 1, 0, 0, 1, 3));
      io.clear_fail = 0;
      step("t3_fault_hold", v(0, 1, 0, 0, 1, 3));
      io.rate_lower_fail = 0; io.clear_fail = 1;
      step("t3_clear_pulse", v(0, 1, 1, 0, 1, 4));
      io.clear_fail = 0;
      repeat (3) step("t3_cooldown", v(0, 1, 0, 0, 1, 4));
      step("t3_cooldown_off", v(0, 1, 0, 0, 1, 0));
      repeat (2) step("t3_no_rearm_held", v(0, 1, 0, 0, 1, 0));
      io.enable_req = 0;
      step("t3_req_low", v(0, 1, 0, 0, 1, 0));
      io.enable_req = 1;
      step("t3_rearm_edge", v(1, 1, 0, 0, 0, 1));
      settle_to_armed("t4");

      io.wdt_en = 1;
      repeat (3) begin
         repeat (14) step("t4_wdt_alive", v(1, 0, 0, 0, 0, 2));
         io.wdt_kick = 1;
         step("t4_wdt_kick", v(1, 0, 0, 0, 0, 2));
         io.wdt_kick = 0;
      end
      repeat (15) step("t4_wdt_pending", v(1, 0, 0, 0, 0, 2));
      step("t4_wdt_timeout", v(0, 1, 0, 1, 6, 3));
      io.wdt_en = 0;

      io.clear_fail = 1;
      step("t5_clear_wdt", v(0, 1, 1, 1, 6, 4));
      io.clear_fail = 0;
      repeat (3) step("t5_cooldown", v(0, 1, 0, 1, 6, 4));
      step("t5_off", v(0, 1, 0, 1, 6, 0));
      io.enable_req = 0;
      step("t5_req_low", v(0, 1, 0, 1, 6, 0));
      io.enable_req = 1;
      step("t5_settle", v(1, 1, 0, 0, 0, 1));
      repeat (2) step("t5_settle_run", v(1, 1, 0, 0, 0, 1));
      io.pwr_good = 0;
      repeat (2) step("t5_pg_sync", v(1, 1, 0, 0, 0, 1));
      step("t5_pg_fault", v(0, 1, 0, 0, 5, 3));

      io.pwr_good = 1; io.clear_fail = 1;
      step("t6_clear", v(0, 1, 1, 0, 5, 4));
      io.clear_fail = 0;
      repeat (3) step("t6_cooldown", v(0, 1, 0, 0, 5, 4));
      step("t6_off", v(0, 1, 0, 0, 5, 0));
      io.enable_req = 0;
      step("t6_req_low", v(0, 1, 0, 0, 5, 0));
      io.enable_req = 1;
      step("t6_settle", v(1, 1, 0, 0, 0, 1));
      settle_to_armed("t6");
      rst = 1;
      step("t6_reset_armed", v(0, 1, 0, 0, 0, 0));
      rst = 0;
      repeat (3) step("t6_held_after_reset", v(0, 1, 0, 0, 0, 0));
      io.enable_req = 0;
      step("t6_req_low2", v(0, 1, 0, 0, 0, 0));
      io.enable_req = 1;
      step("t6_settle2", v(1, 1, 0, 0, 0, 1));
      settle_to_armed("t6b");
      io.enable_req = 0; io.pulse_upper_fail = 1; io.pulse_lower_fail = 1;
      step("prio_fault_over_off", v(0, 1, 0, 0, 2, 3));
      io.pulse_upper_fail = 0; io.pulse_lower_fail = 0;
      step("prio_fault_hold", v(0, 1, 0, 0, 2, 3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
